uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync_fifo.sv | 77 +++++++
 rtl/uart_rx_fifo.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types for the UART receive FIFO: the stored entry
//               layout, the character-timeout state encoding and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;

   typedef struct packed {
      logic                       err;
      logic [UART_DATA_WIDTH-1:0] data;
   } uart_rx_entry_t;

   typedef enum logic [1:0] {
      TO_IDLE     = 2'd0,
      TO_COUNTING = 2'd1,
      TO_FIRED    = 2'd2
   } uart_to_state_t;

   function automatic logic is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : First-word fall-through synchronous FIFO with wrap-bit
//               pointers and registered occupancy flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
   parameter int  WIDTH = 9,
   parameter int  DEPTH = 16,
   localparam int c_lw  = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic [c_lw-1:0]  level,
   output logic [c_lw-1:0]  level_nxt,
   output logic             empty,
   output logic             full
);

   localparam int c_aw = c_lw - 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_lw-1:0]  r_wr_ptr;
   logic [c_lw-1:0]  r_rd_ptr;
   logic [c_lw-1:0]  w_wr_ptr_nxt;
   logic [c_lw-1:0]  w_rd_ptr_nxt;
   logic [c_lw-1:0]  r_level;
   logic             r_empty;
   logic             r_full;
   logic             w_wr_acc;
   logic             w_rd_acc;

   // A write into a full FIFO is allowed when the head leaves in the same cycle.
   assign w_rd_acc     = rd_en & ~r_empty;
   assign w_wr_acc     = wr_en & (~r_full | w_rd_acc);
   assign w_wr_ptr_nxt = r_wr_ptr + c_lw'(w_wr_acc);
   assign w_rd_ptr_nxt = r_rd_ptr + c_lw'(w_rd_acc);
   assign level_nxt    = w_wr_ptr_nxt - w_rd_ptr_nxt;

   always_ff @(posedge clk) begin
      if (w_wr_acc && !rst) begin
         r_mem[r_wr_ptr[c_aw-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_level  <= level_nxt;
         r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
         r_full   <= (w_wr_ptr_nxt[c_aw-1:0] == w_rd_ptr_nxt[c_aw-1:0]) &&
                     (w_wr_ptr_nxt[c_aw] != w_rd_ptr_nxt[c_aw]);
      end
   end

   // Storage is not reset, so the head is masked to zero while empty.
   assign rd_data  = r_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];
   assign rd_valid = ~r_empty;
   assign level    = r_level;
   assign empty    = r_empty;
   assign full     = r_full;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receive FIFO with sticky overrun, watermark flag and an
//               optional character timeout (macro UART_RX_FIFO_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int  DATA_WIDTH     = UART_DATA_WIDTH,
   parameter int  DEPTH          = 16,
   parameter int  TIMEOUT_CYCLES = 4096,
   localparam int c_lw           = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   input  logic                  rx_error,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_err,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [c_lw-1:0]       level,
   output logic                  empty,
   output logic                  full,
   input  logic [c_lw-1:0]       thresh,
   output logic                  thresh_hit,
   output logic                  overrun,
`ifdef UART_RX_FIFO_TIMEOUT_EN
   output logic                  timeout,
`endif
   input  logic                  overrun_clr
);

   uart_rx_entry_t   w_wr_entry;
   uart_rx_entry_t   w_rd_entry;
   logic [c_lw-1:0]  w_level_nxt;
   logic             w_rd_hs;
   logic             r_overrun;
   logic             r_thresh_hit;

   if (DATA_WIDTH != UART_DATA_WIDTH) begin : g_width_check
      $error("uart_rx_fifo: DATA_WIDTH must equal UART_DATA_WIDTH");
   end

   if (!is_pow2(DEPTH)) begin : g_depth_check
      $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
   end

   if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
      $error("uart_rx_fifo: TIMEOUT_CYCLES must be at least 1");
   end

   assign w_wr_entry = '{err: rx_error, data: rx_data};

   uart_sync_fifo #(
      .WIDTH ($bits(uart_rx_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (rx_valid),
      .wr_data   (w_wr_entry),
      .rd_en     (rd_ready),
      .rd_data   (w_rd_entry),
      .rd_valid  (rd_valid),
      .level     (level),
      .level_nxt (w_level_nxt),
      .empty     (empty),
      .full      (full)
   );

   assign rd_data = w_rd_entry.data;
   assign rd_err  = w_rd_entry.err;
   assign w_rd_hs = rd_valid & rd_ready;

   // Watermark is computed from the next occupancy so it lines up with level.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrun    <= 1'b0;
         r_thresh_hit <= 1'b0;
      end else begin
         r_overrun    <= (rx_valid & full & ~w_rd_hs) | (r_overrun & ~overrun_clr);
         r_thresh_hit <= (thresh != '0) && (w_level_nxt >= thresh);
      end
   end

   assign overrun    = r_overrun;
   assign thresh_hit = r_thresh_hit;

`ifdef UART_RX_FIFO_TIMEOUT_EN
   localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

   uart_to_state_t      r_to_state;
   uart_to_state_t      w_to_state_nxt;
   logic [c_cnt_w-1:0]  r_to_cnt;
   logic [c_cnt_w-1:0]  w_to_cnt_nxt;
   logic                w_wr_hs;

   assign w_wr_hs = rx_valid & (~full | w_rd_hs);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_to_state <= TO_IDLE;
         r_to_cnt   <= '0;
      end else begin
         r_to_state <= w_to_state_nxt;
         r_to_cnt   <= w_to_cnt_nxt;
      end
   end

   // FIRED is left only by a pop or by draining, never by the watermark.
   always_comb begin
      w_to_state_nxt = r_to_state;
      w_to_cnt_nxt   = r_to_cnt;
      unique case (r_to_state)
         TO_IDLE: begin
            if (!empty && !r_thresh_hit) begin
               w_to_state_nxt = TO_COUNTING;
               w_to_cnt_nxt   = '0;
            end
         end
         TO_COUNTING: begin
            if (empty || r_thresh_hit) begin
               w_to_state_nxt = TO_IDLE;
            end else if (w_wr_hs || w_rd_hs) begin
               w_to_cnt_nxt = '0;
            end else if (r_to_cnt == c_cnt_last) begin
               w_to_state_nxt = TO_FIRED;
            end else begin
               w_to_cnt_nxt = r_to_cnt + 1'b1;
            end
         end
         TO_FIRED: begin
            if (empty) begin
               w_to_state_nxt = TO_IDLE;
            end else if (w_rd_hs) begin
               w_to_state_nxt = TO_COUNTING;
               w_to_cnt_nxt   = '0;
            end
         end
         default: begin
            w_to_state_nxt = TO_IDLE;
            w_to_cnt_nxt   = '0;
         end
      endcase
   end

   assign timeout = (r_to_state == TO_FIRED);
`else
   // Without the timeout feature the FIFO exposes only data, flags and overrun.
`endif

endmodule
`default_nettype wire
